// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: data handshake, frame config and serial output of the UART transmitter
// break_req exists only when UART_TX_BREAK_EN is defined
interface uart_tx_frame_if #(parameter int DATA_WIDTH = 8, parameter int DIV_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  tx_ready;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic [DIV_WIDTH-1:0]  DIV;
  logic                  TX_OUT;
  logic                  busy;
`ifdef UART_TX_BREAK_EN
  logic                  break_req;
  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, DIV, break_req,
                  input tx_ready, TX_OUT, busy);
  modport slave  (input P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, DIV, break_req,
                  output tx_ready, TX_OUT, busy);
`else
  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, DIV,
                  input tx_ready, TX_OUT, busy);
  modport slave  (input P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, DIV,
                  output tx_ready, TX_OUT, busy);
`endif
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter with baud divider, one-entry holding register, parity, 1/2 stop bits
// Optional line break (break_req) is enabled by defining UART_TX_BREAK_EN
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input logic clk,
  input logic rst,
  uart_tx_frame_if.slave bus
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;
  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_hold, r_shift;
  logic                  r_hold_full, r_par, r_par_en, r_stop2;
  logic [DIV_WIDTH-1:0]  r_div, r_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic                  w_tick, w_wr, w_load, w_brk;
`ifdef UART_TX_BREAK_EN
  logic r_brk;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_brk <= 1'b0;
    else     r_brk <= bus.break_req;
  assign w_brk = r_brk;
`else
  assign w_brk = 1'b0;
`endif
  assign w_tick = r_cnt == r_div;
  assign w_wr   = bus.Data_Valid && !r_hold_full;
  assign w_load = w_next == S_START && r_state != S_START;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = (r_hold_full && !w_brk) ? S_START : S_IDLE;
      S_START:  w_next = w_tick ? S_DATA : S_START;
      S_DATA:   w_next = (w_tick && r_bit_cnt == LAST) ? (r_par_en ? S_PARITY : S_STOP1) : S_DATA;
      S_PARITY: w_next = w_tick ? S_STOP1 : S_PARITY;
      S_STOP1, S_STOP2:
        w_next = !w_tick ? r_state :
                 (r_state == S_STOP1 && r_stop2) ? S_STOP2 :
                 (r_hold_full && !w_brk) ? S_START : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_par_en    <= 1'b0;
      r_stop2     <= 1'b0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_IDLE || w_tick) ? '0 : r_cnt + DIV_WIDTH'(1);
      if (w_wr) begin
        r_hold      <= bus.P_DATA;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
      // config is sampled only here so mid-frame input changes never disturb a frame
      if (w_load) begin
        r_shift   <= r_hold;
        r_par     <= ^r_hold ^ bus.PAR_TYP;
        r_par_en  <= bus.PAR_EN;
        r_stop2   <= bus.STOP2;
        r_div     <= bus.DIV;
        r_bit_cnt <= '0;
      end else if (r_state == S_DATA && w_tick) begin
        r_shift   <= r_shift >> 1;
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
    end
  end
  assign bus.TX_OUT   = r_state == S_START  ? 1'b0 :
                        r_state == S_DATA   ? r_shift[0] :
                        r_state == S_PARITY ? r_par :
                        r_state == S_IDLE   ? !w_brk : 1'b1;
  assign bus.busy     = r_state != S_IDLE;
  assign bus.tx_ready = !r_hold_full;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed stimulus with a frame scoreboard decoding the serial line
module tb_uart_tx_frame;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_tx_frame_if #(.DATA_WIDTH(8), .DIV_WIDTH(8)) bus ();
  uart_tx_frame #(.DATA_WIDTH(8), .DIV_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [8:0] data;
    int         nbits;
    bit         par_en;
    bit         par;
    bit         stop2;
    int         div;
    bit         b2b;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic push(input logic [8:0] d, input bit pe, input bit p, input bit s2, input int dv, input bit b2b);
    exp_t e;
    e.data = d; e.nbits = 8; e.par_en = pe; e.par = p; e.stop2 = s2; e.div = dv; e.b2b = b2b;
    q.push_back(e);
  endtask
  task automatic write(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    while (bus.tx_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      checks++; errors++;
      $display("FAIL write_timeout actual=tx_ready_low required=tx_ready_high");
    end
    bus.P_DATA = d;
    bus.Data_Valid = 1'b1;
    @(posedge clk);
    #1 bus.Data_Valid = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    @(posedge clk);
    #1;
    while (bus.busy !== 1'b0 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 5000) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask
  // monitor: decodes each frame cycle by cycle against the popped expectation
  initial begin
    exp_t cur;
    bit in_frame = 0, chk_gap = 0, bad = 0;
    logic [15:0] bits;
    logic obs;
    int n, idx, cyc;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 0;
        chk_gap = 0;
        chk("rst_tx", bus.TX_OUT, 1);
        chk("rst_busy", bus.busy, 0);
      end else begin
        if (!in_frame) begin
          if (chk_gap) chk("gap_busy", bus.busy, (q.size() > 0 && q[0].b2b) ? 1 : 0);
          chk_gap = 0;
          if (bus.busy === 1'b1 && bus.TX_OUT === 1'b0) begin
            if (q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_frame actual=start required=idle");
              while (bus.busy === 1'b1 && !rst) @(negedge clk);
            end else begin
              cur = q.pop_front();
              bits = '1;
              bits[0] = 1'b0;
              for (int i = 0; i < cur.nbits; i++) bits[1+i] = cur.data[i];
              n = 1 + cur.nbits;
              if (cur.par_en) begin bits[n] = cur.par; n++; end
              bits[n] = 1'b1; n++;
              if (cur.stop2) begin bits[n] = 1'b1; n++; end
              in_frame = 1; idx = 0; cyc = 0; bad = 0; obs = 1'b0;
            end
          end
        end
        if (in_frame) begin
          if (bus.TX_OUT !== bits[idx] || bus.busy !== 1'b1) begin bad = 1; obs = bus.TX_OUT; end
          cyc++;
          if (cyc == cur.div + 1) begin
            checks++;
            if (bad) begin
              errors++;
              $display("FAIL bit%0d data=%0h actual=%b busy=%b required=%b", idx, cur.data, obs, bus.busy, bits[idx]);
            end
            bad = 0; cyc = 0; idx++;
            if (idx == n) begin in_frame = 0; chk_gap = 1; end
          end
        end
      end
    end
  end
  initial begin
    int cnt;
    bus.P_DATA = '0; bus.Data_Valid = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    bus.STOP2 = 1'b0; bus.DIV = 8'd3;
`ifdef UART_TX_BREAK_EN
    bus.break_req = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("idle_tx", bus.TX_OUT, 1);
      chk("idle_busy", bus.busy, 0);
      chk("idle_ready", bus.tx_ready, 1);
    end
    push(9'h0A5, 0, 0, 0, 3, 0);
    write(8'hA5);
    chk("wr_ready", bus.tx_ready, 0);
    chk("wr_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    chk("start_tx", bus.TX_OUT, 0);
    chk("start_busy", bus.busy, 1);
    chk("start_ready", bus.tx_ready, 1);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("busy_len", cnt, 40);
    chk("end_tx", bus.TX_OUT, 1);
    bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1; bus.DIV = 8'd0;
    push(9'h007, 1, 0, 0, 0, 0);
    write(8'h07);
    wait_idle();
    bus.PAR_TYP = 1'b0;
    push(9'h007, 1, 1, 0, 0, 0);
    write(8'h07);
    wait_idle();
    bus.PAR_EN = 1'b0; bus.DIV = 8'd2;
    push(9'h055, 0, 0, 0, 2, 0);
    write(8'h55);
    push(9'h0AA, 0, 0, 0, 2, 1);
    write(8'hAA);
    @(negedge clk);
    chk("drop_ready", bus.tx_ready, 0);
    bus.P_DATA = 8'hFF;
    bus.Data_Valid = 1'b1;
    @(posedge clk);
    #1 bus.Data_Valid = 1'b0;
    wait_idle();
    bus.STOP2 = 1'b1; bus.DIV = 8'd1;
    push(9'h03C, 0, 0, 1, 1, 0);
    write(8'h3C);
    @(posedge clk);
    #1 bus.DIV = 8'd9;
    push(9'h081, 0, 0, 1, 9, 1);
    write(8'h81);
    wait_idle();
    bus.STOP2 = 1'b0; bus.DIV = 8'd3;
    push(9'h0F0, 0, 0, 0, 3, 0);
    write(8'hF0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_tx", bus.TX_OUT, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ready", bus.tx_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push(9'h03C, 0, 0, 0, 3, 0);
    write(8'h3C);
    wait_idle();
`ifdef UART_TX_BREAK_EN
    bus.break_req = 1'b1;
    @(posedge clk);
    #1;
    push(9'h03C, 0, 0, 0, 3, 0);
    write(8'h3C);
    repeat (30) begin
      @(posedge clk);
      #1;
      chk("brk_tx", bus.TX_OUT, 0);
      chk("brk_busy", bus.busy, 0);
    end
    bus.break_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_tx", bus.TX_OUT, 1);
    chk("rel_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    chk("rel_start_tx", bus.TX_OUT, 0);
    chk("rel_start_busy", bus.busy, 1);
    wait_idle();
`endif
    repeat (5) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
